// File: rtl/buffer_shift_ctrl.sv
// Control-side sequencer for the buffer shift register: RAM reads, per-cycle codes, window valid tracking.
// Optional BUFFER_SHIFT_CTRL_PERF_EN adds a busy-cycle counter on perf_cycles.
module buffer_shift_ctrl #(
   parameter int X_MAC      = 4,
   parameter int MUXCONTROL = 4,
   parameter int ADDR_W     = 10,
   parameter int LEN_W      = 8,
   parameter int OUT_LAT    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pad_en,
   input  logic                  swap_en,
   input  logic [LEN_W-1:0]      row_words,
   input  logic [LEN_W-1:0]      num_rows,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     row_stride,
   input  logic [X_MAC*2-1:0]    buffermux_cfg,
   input  logic [X_MAC-1:0]      iszero_cfg,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   output logic [MUXCONTROL-1:0] control,
   output logic [X_MAC*2-1:0]    buffermux,
   output logic [X_MAC-1:0]      iszero,
   output logic                  win_valid,
   output logic                  win_last,
   output logic                  busy,
   output logic                  done
`ifdef BUFFER_SHIFT_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);

   localparam logic [MUXCONTROL-1:0] C_IDLE = '1;
   localparam logic [MUXCONTROL-1:0] C_END1 = MUXCONTROL'(8);
   localparam logic [MUXCONTROL-1:0] C_END2 = MUXCONTROL'(9);

   // Each state names the code driven in the cycle after the edge it is seen on.
   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_UINIT1, S_UINIT2, S_TAIL1, S_TAIL2, S_GAP, S_DRAIN
   } state_t;

   state_t state;

   logic                  pad_q, swap_q;
   logic [LEN_W-1:0]      words_q, rows_q, word, row_cnt;
   logic [ADDR_W-1:0]     stride_q, row_base;
   logic [X_MAC*2-1:0]    bm_q;
   logic [X_MAC-1:0]      iz_q;
   logic [OUT_LAT:0]      vld_pipe, last_pipe;

   logic [MUXCONTROL-1:0] init_code, u1_code, u2_code;
   logic                  row_last;
   state_t                row_end_state;

   assign init_code     = pad_q ? MUXCONTROL'({1'b0, swap_q}) : MUXCONTROL'({3'b010, swap_q});
   assign u1_code       = pad_q ? MUXCONTROL'(2) : MUXCONTROL'(6);
   assign u2_code       = pad_q ? MUXCONTROL'(3) : MUXCONTROL'(7);
   assign row_last      = (row_cnt == rows_q - LEN_W'(1));
   assign row_end_state = row_last ? S_DRAIN : S_GAP;

   assign win_valid = vld_pipe[OUT_LAT];
   assign win_last  = last_pipe[OUT_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         pad_q     <= 1'b0;
         swap_q    <= 1'b0;
         words_q   <= '0;
         rows_q    <= '0;
         word      <= '0;
         row_cnt   <= '0;
         stride_q  <= '0;
         row_base  <= '0;
         bm_q      <= '0;
         iz_q      <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         control   <= C_IDLE;
         buffermux <= 8'b11_10_01_00;
         iszero    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_en     <= 1'b0;
         done      <= 1'b0;
         vld_pipe  <= {vld_pipe[OUT_LAT-1:0], 1'b0};
         last_pipe <= {last_pipe[OUT_LAT-1:0], 1'b0};
         case (state)
            S_IDLE: begin
               control <= C_IDLE;
               if (start) begin
                  pad_q    <= pad_en;
                  swap_q   <= swap_en;
                  words_q  <= (row_words == '0) ? LEN_W'(1) : row_words;
                  rows_q   <= num_rows;
                  stride_q <= row_stride;
                  bm_q     <= buffermux_cfg;
                  iz_q     <= iszero_cfg;
                  row_cnt  <= '0;
                  row_base <= base_addr;
                  if (num_rows == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy    <= 1'b1;
                     rd_en   <= 1'b1;
                     rd_addr <= base_addr;
                     state   <= S_INIT;
                  end
               end
            end
            S_INIT: begin
               control     <= init_code;
               buffermux   <= bm_q;
               iszero      <= iz_q;
               vld_pipe[0] <= 1'b1;
               word        <= LEN_W'(1);
               if (words_q != LEN_W'(1)) begin
                  rd_en   <= 1'b1;
                  rd_addr <= row_base + ADDR_W'(1);
                  state   <= S_UINIT1;
               end else if (pad_q) begin
                  state <= S_TAIL1;
               end else begin
                  last_pipe[0] <= 1'b1;
                  state        <= row_end_state;
               end
            end
            S_UINIT1: begin
               control     <= u1_code;
               vld_pipe[0] <= 1'b1;
               state       <= S_UINIT2;
            end
            S_UINIT2: begin
               control     <= u2_code;
               vld_pipe[0] <= 1'b1;
               // Next word's read overlaps this code so its UINIT_1 sees RAM data.
               if (word != words_q - LEN_W'(1)) begin
                  rd_en   <= 1'b1;
                  rd_addr <= row_base + ADDR_W'(word) + ADDR_W'(1);
                  word    <= word + LEN_W'(1);
                  state   <= S_UINIT1;
               end else if (pad_q) begin
                  state <= S_TAIL1;
               end else begin
                  last_pipe[0] <= 1'b1;
                  state        <= row_end_state;
               end
            end
            S_TAIL1: begin
               control     <= C_END1;
               vld_pipe[0] <= 1'b1;
               state       <= S_TAIL2;
            end
            S_TAIL2: begin
               control      <= C_END2;
               vld_pipe[0]  <= 1'b1;
               last_pipe[0] <= 1'b1;
               state        <= row_end_state;
            end
            S_GAP: begin
               control  <= C_IDLE;
               rd_en    <= 1'b1;
               rd_addr  <= row_base + stride_q;
               row_base <= row_base + stride_q;
               row_cnt  <= row_cnt + LEN_W'(1);
               state    <= S_INIT;
            end
            S_DRAIN: begin
               control <= C_IDLE;
               if (vld_pipe[OUT_LAT-1:0] == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef BUFFER_SHIFT_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         perf_cycles <= '0;
      else if (state == S_IDLE && start)
         perf_cycles <= '0;
      else if (busy)
         perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_buffer_shift_ctrl.sv
// Bench for buffer_shift_ctrl: per-cycle expected timeline built from the tile rules, compared every cycle.
module tb_buffer_shift_ctrl;
   localparam int OUT_LAT = 3;
   localparam int MAXC    = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, pad_en = 1'b0, swap_en = 1'b0;
   logic [7:0] row_words = '0, num_rows = '0;
   logic [9:0] base_addr = '0, row_stride = '0;
   logic [7:0] buffermux_cfg = '0;
   logic [3:0] iszero_cfg = '0;
   logic       rd_en, win_valid, win_last, busy, done;
   logic [9:0] rd_addr;
   logic [3:0] control, iszero;
   logic [7:0] buffermux;
`ifdef BUFFER_SHIFT_CTRL_PERF_EN
   logic [31:0] perf_cycles;
`endif

   buffer_shift_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .pad_en(pad_en), .swap_en(swap_en),
      .row_words(row_words), .num_rows(num_rows), .base_addr(base_addr),
      .row_stride(row_stride), .buffermux_cfg(buffermux_cfg), .iszero_cfg(iszero_cfg),
      .rd_en(rd_en), .rd_addr(rd_addr), .control(control), .buffermux(buffermux),
      .iszero(iszero), .win_valid(win_valid), .win_last(win_last), .busy(busy),
      .done(done)
`ifdef BUFFER_SHIFT_CTRL_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       e_rd   [MAXC];
   logic [9:0] e_addr [MAXC];
   logic [3:0] e_ctl  [MAXC];
   logic       e_wv   [MAXC];
   logic       e_wl   [MAXC];
   logic       e_busy [MAXC];
   logic       e_done [MAXC];
   int         done_off;
   logic [7:0] prev_bm;
   logic [3:0] prev_iz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Timeline from the rules: codes start 2 cycles after start, one F gap between rows,
   // word k read one cycle before its UINIT_1, windows OUT_LAT after each code.
   task automatic build(input logic pad, input logic swap, input int words, input int rows,
                        input logic [9:0] base, input logic [9:0] stride);
      int w, c, n;
      int codes[$];
      logic [9:0] rb;
      for (int i = 0; i < MAXC; i++) begin
         e_rd[i] = 0; e_addr[i] = '0; e_ctl[i] = 4'hF;
         e_wv[i] = 0; e_wl[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      end
      if (rows == 0) begin
         done_off = 1; e_done[1] = 1;
         return;
      end
      w = (words == 0) ? 1 : words;
      c = 2;
      for (int r = 0; r < rows; r++) begin
         rb = base + 10'(r) * stride;
         codes.delete();
         codes.push_back(pad ? (swap ? 1 : 0) : (swap ? 5 : 4));
         e_rd[c-1] = 1; e_addr[c-1] = rb;
         for (int k = 1; k < w; k++) begin
            e_rd[c+2*k-2] = 1; e_addr[c+2*k-2] = rb + 10'(k);
            codes.push_back(pad ? 2 : 6);
            codes.push_back(pad ? 3 : 7);
         end
         if (pad) begin codes.push_back(8); codes.push_back(9); end
         n = codes.size();
         for (int j = 0; j < n; j++) begin
            e_ctl[c+j] = 4'(codes[j]);
            e_wv[c+j+OUT_LAT] = 1;
         end
         e_wl[c+n-1+OUT_LAT] = 1;
         c += n;
         if (r < rows - 1) c++;
      end
      done_off = (c - 1) + OUT_LAT + 1;
      e_done[done_off] = 1;
      for (int i = 1; i < done_off; i++) e_busy[i] = 1;
   endtask

   task automatic run(input logic pad, input logic swap, input int words, input int rows,
                      input logic [9:0] base, input logic [9:0] stride,
                      input logic [7:0] bm, input logic [3:0] iz, input logic disturb);
      build(pad, swap, words, rows, base, stride);
      pad_en = pad; swap_en = swap; row_words = 8'(words); num_rows = 8'(rows);
      base_addr = base; row_stride = stride; buffermux_cfg = bm; iszero_cfg = iz;
      start = 1'b1;
      for (int off = 1; off <= done_off + 2; off++) begin
         @(posedge clk); #1;
         if (off == 1) start = 1'b0;
         chk($sformatf("rd_en@%0d", off), rd_en, e_rd[off]);
         if (e_rd[off]) chk($sformatf("rd_addr@%0d", off), rd_addr, e_addr[off]);
         chk($sformatf("control@%0d", off), control, e_ctl[off]);
         chk($sformatf("win_valid@%0d", off), win_valid, e_wv[off]);
         chk($sformatf("win_last@%0d", off), win_last, e_wl[off]);
         chk($sformatf("busy@%0d", off), busy, e_busy[off]);
         chk($sformatf("done@%0d", off), done, e_done[off]);
         chk($sformatf("buffermux@%0d", off), buffermux, (rows > 0 && off >= 2) ? bm : prev_bm);
         chk($sformatf("iszero@%0d", off), iszero, (rows > 0 && off >= 2) ? iz : prev_iz);
`ifdef BUFFER_SHIFT_CTRL_PERF_EN
         if (off >= done_off) chk("perf_cycles", perf_cycles, 32'(done_off - 1));
`endif
         if (disturb && off == 3) begin
            start = 1'b1;
            pad_en = ~pad; swap_en = ~swap; row_words = 8'($urandom_range(0, 6));
            num_rows = 8'($urandom_range(0, 4)); base_addr = 10'($urandom);
            row_stride = 10'($urandom); buffermux_cfg = 8'($urandom); iszero_cfg = 4'($urandom);
         end
         if (off == 4) start = 1'b0;
      end
      if (rows > 0) begin prev_bm = bm; prev_iz = iz; end
   endtask

   initial begin
      prev_bm = 8'b11_10_01_00;
      prev_iz = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_control", control, 4'hF);
      chk("rst_buffermux", buffermux, 8'b11_10_01_00);
      chk("rst_iszero", iszero, 4'h0);
      chk("rst_outs", {rd_en, rd_addr, win_valid, win_last, busy, done}, '0);

      run(1'b1, 1'b0, 3, 1, 10'h010, 10'h000, 8'hA5, 4'h3, 1'b0);
      run(1'b0, 1'b1, 2, 2, 10'h3FE, 10'h004, 8'h1B, 4'h9, 1'b0);
      run(1'b0, 1'b0, 0, 1, 10'h123, 10'h000, 8'h3C, 4'h5, 1'b0);
      run(1'b1, 1'b1, 2, 0, 10'h200, 10'h010, 8'hFF, 4'hF, 1'b0);
      run(1'b1, 1'b0, 4, 2, 10'h0F0, 10'h020, 8'h66, 4'hA, 1'b1);

      // Abort mid-stream with reset, then confirm a clean restart.
      build(1'b1, 1'b0, 4, 2, 10'h040, 10'h010);
      pad_en = 1'b1; swap_en = 1'b0; row_words = 8'd4; num_rows = 8'd2;
      base_addr = 10'h040; row_stride = 10'h010; buffermux_cfg = 8'h5A; iszero_cfg = 4'h6;
      start = 1'b1;
      for (int off = 1; off <= 5; off++) begin
         @(posedge clk); #1;
         start = 1'b0;
         chk($sformatf("pre_rst_control@%0d", off), control, e_ctl[off]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_control", control, 4'hF);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_buffermux", buffermux, 8'b11_10_01_00);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("abort_quiet", {done, win_valid, rd_en, busy}, 4'h0);
      end
      prev_bm = 8'b11_10_01_00;
      prev_iz = 4'h0;
      run(1'b1, 1'b0, 3, 1, 10'h010, 10'h000, 8'hC3, 4'h1, 1'b0);

      for (int t = 0; t < 20; t++) begin
         int rws, nr;
         logic p, s;
         rws = $urandom_range(0, 4);
         nr  = $urandom_range(0, 3);
         p   = 1'($urandom);
         s   = 1'($urandom);
         run(p, s, rws, nr, 10'($urandom), 10'($urandom), 8'($urandom), 4'($urandom),
             (nr > 0) ? 1'($urandom) : 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
